// File: rtl/traffic_phase_sequencer.sv
// Timed phase source: walks NS_GREEN -> NS_AMBER -> EW_GREEN -> EW_AMBER on prescaled ticks,
// with a latched pedestrian request allowed to cut a green short after its minimum dwell.
module traffic_phase_sequencer #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned T_GREEN     = 20,
  parameter int unsigned T_AMBER     = 3,
  parameter int unsigned T_MIN_GREEN = 5,
  parameter int unsigned CW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          ped_req,
  output logic          step_bit,
  output logic [1:0]    phase,
  output logic          amber,
  output logic [CW-1:0] remaining,
  output logic          ped_ack
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] GREEN_T    = CW'(T_GREEN);
  localparam logic [CW-1:0] AMBER_T    = CW'(T_AMBER);
  localparam logic [CW-1:0] MIN_GREEN  = CW'(T_MIN_GREEN);

  typedef enum logic [1:0] {
    NS_GREEN = 2'd0,
    NS_AMBER = 2'd1,
    EW_GREEN = 2'd2,
    EW_AMBER = 2'd3
  } phase_t;

  phase_t        state;
  phase_t        next_state;
  logic [PW-1:0] presc;
  logic          ped_pending;
  logic          tick;
  logic          in_green;
  logic          early_out;
  logic          advance;

  // Elapsed green ticks are T_GREEN - remaining; remaining never exceeds T_GREEN in green.
  always_comb begin
    tick       = en && (presc == PRESC_LAST);
    in_green   = ~state[0];
    early_out  = in_green && ped_pending && ((GREEN_T - remaining) >= MIN_GREEN);
    advance    = tick && ((remaining == CW'(1)) || early_out);
    next_state = phase_t'(state + 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NS_GREEN;
      step_bit    <= 1'b0;
      amber       <= 1'b0;
      remaining   <= GREEN_T;
      presc       <= '0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      if (en) presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      // A green ending with a request pending consumes it; a same-cycle request re-arms it.
      ped_ack     <= advance && in_green && ped_pending;
      ped_pending <= ped_req || (ped_pending && !(advance && in_green));
      if (advance) begin
        state     <= next_state;
        step_bit  <= next_state[0];
        amber     <= next_state[0];
        remaining <= next_state[0] ? AMBER_T : GREEN_T;
      end else if (tick) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: directed schedule tables, multi-cycle corner sequences,
// and randomized en/ped_req traffic compared against an elapsed-tick reference model.
module tb_traffic_phase_sequencer;

  localparam int unsigned TD  = 2;
  localparam int unsigned TG  = 4;
  localparam int unsigned TA  = 2;
  localparam int unsigned TMG = 2;
  localparam int unsigned CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          ped_req = 1'b0;
  logic          step_bit;
  logic [1:0]    phase;
  logic          amber;
  logic [CW-1:0] remaining;
  logic          ped_ack;

  traffic_phase_sequencer #(
    .TICK_DIV   (TD),
    .T_GREEN    (TG),
    .T_AMBER    (TA),
    .T_MIN_GREEN(TMG),
    .CW         (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ped_req  (ped_req),
    .step_bit (step_bit),
    .phase    (phase),
    .amber    (amber),
    .remaining(remaining),
    .ped_ack  (ped_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Reference model: enabled-cycle count, phase index, ticks elapsed in phase, pending flag.
  int m_cnt, m_phase, m_el;
  bit m_pend, m_ack;

  typedef struct {
    int edge_no;
    int ph;
    int rem;
  } sched_t;

  sched_t sched[$];

  task automatic mdl_reset();
    m_cnt = 0; m_phase = 0; m_el = 0; m_pend = 0; m_ack = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ph, input int rem, input int ack);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".step_bit"}, 32'(step_bit), 32'(ph % 2));
    chk({tag, ".amber"}, 32'(amber), 32'(ph % 2));
    chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
    chk({tag, ".ped_ack"}, 32'(ped_ack), 32'(ack));
  endtask

  task automatic clk_step();
    bit tk, adv, even;
    int dwell;
    @(posedge clk);
    tk = en && (m_cnt == int'(TD) - 1);
    if (en) m_cnt = (m_cnt + 1) % int'(TD);
    even  = (m_phase % 2) == 0;
    dwell = even ? int'(TG) : int'(TA);
    adv   = tk && ((m_el + 1 == dwell) || (even && m_pend && m_el >= int'(TMG)));
    m_ack = adv && even && m_pend;
    if (adv) begin
      m_phase = (m_phase + 1) % 4;
      m_el = 0;
    end else if (tk) begin
      m_el++;
    end
    m_pend = ped_req || (m_pend && !(adv && even));
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) clk_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    edge_n = 0;
    mdl_reset();
  endtask

  task automatic run_sched(input string tag);
    foreach (sched[i]) begin
      run_to(sched[i].edge_no);
      check_out(tag, sched[i].ph, sched[i].rem, 0);
    end
  endtask

  initial begin
    int toggles;
    logic prev_step;

    sched = '{
      '{0, 0, 4}, '{2, 0, 3}, '{6, 0, 1}, '{7, 0, 1}, '{8, 1, 2}, '{11, 1, 1},
      '{12, 2, 4}, '{19, 2, 1}, '{20, 3, 2}, '{23, 3, 1}, '{24, 0, 4}
    };

    // Plain schedule with no requests
    do_reset();
    run_sched("sched");

    // Request at cycle 1 cuts NS green at the third tick; amber still runs full length
    do_reset();
    ped_req = 1'b1;
    clk_step();
    ped_req = 1'b0;
    run_to(5);  check_out("ped_ns.pre", 0, 2, 0);
    run_to(6);  check_out("ped_ns.cut", 1, 2, 1);
    run_to(7);  check_out("ped_ns.ack1", 1, 2, 0);
    run_to(9);  check_out("ped_ns.amb", 1, 1, 0);
    run_to(10); check_out("ped_ns.ew", 2, 4, 0);

    // Request during NS amber leaves amber intact, then shortens EW green
    do_reset();
    run_to(8);
    ped_req = 1'b1;
    clk_step();
    ped_req = 1'b0;
    run_to(11); check_out("ped_amb.amb", 1, 1, 0);
    run_to(12); check_out("ped_amb.ew", 2, 4, 0);
    run_to(17); check_out("ped_amb.pre", 2, 2, 0);
    run_to(18); check_out("ped_amb.cut", 3, 2, 1);
    run_to(19); check_out("ped_amb.ack1", 3, 2, 0);

    // en low for cycles 3..12 freezes everything and delays the schedule by 10
    do_reset();
    run_to(2);
    en = 1'b0;
    run_to(12); check_out("hold.frozen", 0, 3, 0);
    en = 1'b1;
    run_to(17); check_out("hold.pre", 0, 1, 0);
    run_to(18); check_out("hold.adv", 1, 2, 0);

    // Request latched while en is low is acted on once timing resumes
    do_reset();
    run_to(2);
    en = 1'b0;
    run_to(4);
    ped_req = 1'b1;
    clk_step();
    ped_req = 1'b0;
    run_to(12); check_out("hold_ped.frozen", 0, 3, 0);
    en = 1'b1;
    run_to(15); check_out("hold_ped.pre", 0, 2, 0);
    run_to(16); check_out("hold_ped.cut", 1, 2, 1);

    // Asynchronous reset mid EW green, then the schedule replays from release
    do_reset();
    run_to(14);
    check_out("mid.ew", 2, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid.rst", 0, 4, 0);
    mdl_reset();
    @(posedge clk);
    #1;
    check_out("mid.held", 0, 4, 0);
    rst_n = 1'b1;
    edge_n = 0;
    run_sched("mid.sched");

    // Random en/ped_req against the reference model; phase must track step_bit toggles
    do_reset();
    toggles = 0;
    prev_step = step_bit;
    for (int i = 0; i < 4000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      ped_req = ($urandom_range(0, 19) == 0);
      clk_step();
      check_out("rand", m_phase, ((m_phase % 2) == 0 ? int'(TG) : int'(TA)) - m_el, int'(m_ack));
      if (step_bit !== prev_step) toggles++;
      prev_step = step_bit;
    end
    chk("rand.toggle_phase", 32'(phase), 32'(toggles % 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
